// File: rtl/uart_alu_if_if.sv
// Bundle between uart_rx/uart_tx/ALU and the command sequencer.
// Latency: none (wires only).
// Backpressure: i_tx_busy stalls the transmit start; rx bytes have no backpressure.
interface uart_alu_if_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
);
  logic [NB_DATA-1:0] i_rx_data;
  logic               i_rx_done;
  logic [NB_DATA-1:0] i_alu_result;
  logic               i_tx_busy;
  logic               i_tx_done;
  logic [NB_DATA-1:0] o_data_a;
  logic [NB_DATA-1:0] o_data_b;
  logic [NB_OP-1:0]   o_op;
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_tx_start;
  logic               o_overrun;
  logic               o_timeout;

  // Environment side: drives rx bytes, ALU result and tx status.
  modport master (
    output i_rx_data, i_rx_done, i_alu_result, i_tx_busy, i_tx_done,
    input  o_data_a, o_data_b, o_op, o_tx_data, o_tx_start, o_overrun, o_timeout
  );

  // Sequencer side.
  modport slave (
    input  i_rx_data, i_rx_done, i_alu_result, i_tx_busy, i_tx_done,
    output o_data_a, o_data_b, o_op, o_tx_data, o_tx_start, o_overrun, o_timeout
  );
endinterface

// File: rtl/uart_alu_if.sv
// Collects A, B, opcode bytes from uart_rx, latches the ALU result, launches uart_tx.
// Latency: op byte at edge N -> o_tx_data after N+1, o_tx_start pulse after N+2.
// Backpressure: waits while i_tx_busy; bytes arriving while busy are dropped (o_overrun).
// Optional inter-byte timeout enabled by defining UART_IF_TIMEOUT_EN.
module uart_alu_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
`ifdef UART_IF_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1_000_000
`endif
) (
  input logic          clk,
  input logic          i_rst_n,
  uart_alu_if_if.slave bus
);

  typedef enum logic [2:0] {
    S_WAIT_A, S_WAIT_B, S_WAIT_OP, S_EXEC, S_SEND, S_WAIT_TX
  } state_t;

  state_t             state_q, state_d;
  logic [NB_DATA-1:0] data_a_q, data_a_d;
  logic [NB_DATA-1:0] data_b_q, data_b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               overrun_q, overrun_d;

`ifdef UART_IF_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             expired;

  assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  // Next-state and register updates; defaults hold everything, pulses drop to 0.
  always_comb begin
    state_d    = state_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    overrun_d  = overrun_q;
`ifdef UART_IF_TIMEOUT_EN
    cnt_d      = '0;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      S_WAIT_A: begin
        if (bus.i_rx_done) begin
          data_a_d = bus.i_rx_data;
          state_d  = S_WAIT_B;
        end
      end
      S_WAIT_B: begin
        if (bus.i_rx_done) begin
          data_b_d = bus.i_rx_data;
          state_d  = S_WAIT_OP;
        end
`ifdef UART_IF_TIMEOUT_EN
        else if (expired) begin
          state_d   = S_WAIT_A;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_WAIT_OP: begin
        if (bus.i_rx_done) begin
          op_d    = bus.i_rx_data[NB_OP-1:0];
          state_d = S_EXEC;
        end
`ifdef UART_IF_TIMEOUT_EN
        else if (expired) begin
          state_d   = S_WAIT_A;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_EXEC: begin
        // Operands/opcode registered last cycle; the ALU output has settled now.
        tx_data_d = bus.i_alu_result;
        state_d   = S_SEND;
      end
      S_SEND: begin
        if (!bus.i_tx_busy) begin
          tx_start_d = 1'b1;
          state_d    = S_WAIT_TX;
        end
      end
      S_WAIT_TX: begin
        if (bus.i_tx_done) state_d = S_WAIT_A;
      end
      default: state_d = S_WAIT_A;
    endcase
    // No room for a byte once the command is complete; drop it and flag it.
    if (bus.i_rx_done && (state_q == S_EXEC || state_q == S_SEND || state_q == S_WAIT_TX))
      overrun_d = 1'b1;
  end

  // State register with synchronous active-low reset clearing every output.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state_q    <= S_WAIT_A;
      data_a_q   <= '0;
      data_b_q   <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef UART_IF_TIMEOUT_EN
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      overrun_q  <= overrun_d;
`ifdef UART_IF_TIMEOUT_EN
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign bus.o_data_a   = data_a_q;
  assign bus.o_data_b   = data_b_q;
  assign bus.o_op       = op_q;
  assign bus.o_tx_data  = tx_data_q;
  assign bus.o_tx_start = tx_start_q;
  assign bus.o_overrun  = overrun_q;
`ifdef UART_IF_TIMEOUT_EN
  assign bus.o_timeout  = timeout_q;
`else
  assign bus.o_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_alu_if.sv
// Directed bench for uart_alu_if with a result scoreboard.
// Drives inputs 1ns after the rising edge and samples there too.
// Timeout scenario only runs when UART_IF_TIMEOUT_EN is defined.
module tb_uart_alu_if;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  uart_alu_if_if #(.NB_DATA(8), .NB_OP(6)) bus ();

`ifdef UART_IF_TIMEOUT_EN
  uart_alu_if #(.NB_DATA(8), .NB_OP(6), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .i_rst_n(rst_n), .bus(bus));
`else
  uart_alu_if #(.NB_DATA(8), .NB_OP(6)) dut (
    .clk(clk), .i_rst_n(rst_n), .bus(bus));
`endif

  // External ALU: 0x20 add, 0x22 subtract, anything else xor.
  function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b,
                                     input logic [5:0] op);
    case (op)
      6'h20:   alu = a + b;
      6'h22:   alu = a - b;
      default: alu = a ^ b;
    endcase
  endfunction

  always_comb bus.i_alu_result = alu(bus.o_data_a, bus.o_data_b, bus.o_op);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    tick();
    bus.i_rx_done = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_a"},       bus.o_data_a, 0);
    chk({tag, "_b"},       bus.o_data_b, 0);
    chk({tag, "_op"},      bus.o_op, 0);
    chk({tag, "_txd"},     bus.o_tx_data, 0);
    chk({tag, "_start"},   bus.o_tx_start, 0);
    chk({tag, "_overrun"}, bus.o_overrun, 0);
    chk({tag, "_timeout"}, bus.o_timeout, 0);
  endtask

  // One full command. hold: cycles tx_busy stays high after the op byte.
  // extra: inject a stray byte while the frame is being sent.
  // finish_tx: 0 leaves the DUT waiting for i_tx_done with busy high.
  task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                         input int hold, input bit extra, input bit finish_tx);
    int k;
    int exp_k;
    logic [7:0] held;
    bit stable;
    send_byte(a);
    send_byte(b);
    sb.push_back(alu(a, b, op[5:0]));
    if (hold > 0) bus.i_tx_busy = 1'b1;
    send_byte(op);
    chk("data_a", bus.o_data_a, a);
    chk("data_b", bus.o_data_b, b);
    chk("op", bus.o_op, op & 8'h3f);
    exp_k = (hold == 0) ? 2 : hold + 1;
    k = 0;
    while (k < 60 && bus.o_tx_start !== 1'b1) begin
      tick();
      k++;
      if (hold > 0 && k == hold) bus.i_tx_busy = 1'b0;
    end
    chk("start_latency", k, exp_k);
    chk("sb_depth", sb.size(), 1);
    chk("tx_data", bus.o_tx_data, sb.pop_front());
    held = bus.o_tx_data;
    bus.i_tx_busy = 1'b1;
    tick();
    chk("start_pulse", bus.o_tx_start, 0);
    if (!finish_tx) return;
    stable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.o_tx_data !== held || bus.o_tx_start !== 1'b0) stable = 1'b0;
    end
    if (extra) begin
      send_byte(8'hAA);
      if (bus.o_tx_data !== held || bus.o_tx_start !== 1'b0) stable = 1'b0;
    end
    chk("tx_stable", stable, 1);
    bus.i_tx_busy = 1'b0;
    bus.i_tx_done = 1'b1;
    tick();
    bus.i_tx_done = 1'b0;
  endtask

  initial begin
    bit quiet;
`ifdef UART_IF_TIMEOUT_EN
    int k;
`endif
    rst_n = 1'b0;
    bus.i_rx_data = '0;
    bus.i_rx_done = 1'b0;
    bus.i_tx_busy = 1'b0;
    bus.i_tx_done = 1'b0;
    tick();
    tick();
    check_zero("rst");
    rst_n = 1'b1;
    tick();

    // rx data without rx_done and a stray tx_done must be ignored
    bus.i_rx_data = 8'h99;
    bus.i_tx_done = 1'b1;
    tick();
    bus.i_tx_done = 1'b0;
    tick();
    chk("no_done_a", bus.o_data_a, 0);

    // basic add, 2-cycle start latency
    run_cmd(8'h05, 8'h03, 8'h20, 0, 1'b0, 1'b1);
    chk("overrun_clear", bus.o_overrun, 0);
    // upper opcode bits dropped (0xE2 -> 0x22 subtract), 10 busy cycles
    run_cmd(8'h10, 8'h03, 8'hE2, 10, 1'b0, 1'b1);
    // wrap-around and xor opcode
    run_cmd(8'hFF, 8'h01, 8'h20, 0, 1'b0, 1'b1);
    run_cmd(8'h5A, 8'h0F, 8'h01, 3, 1'b0, 1'b1);

    // stray byte while transmitting sets sticky overrun
    run_cmd(8'h21, 8'h12, 8'h20, 0, 1'b1, 1'b1);
    chk("overrun_set", bus.o_overrun, 1);
    run_cmd(8'h01, 8'h01, 8'h20, 0, 1'b0, 1'b1);
    chk("overrun_sticky", bus.o_overrun, 1);

    // reset in S_WAIT_OP
    send_byte(8'h11);
    send_byte(8'h22);
    rst_n = 1'b0;
    bus.i_rx_data = 8'h20;
    bus.i_rx_done = 1'b1;
    tick();
    bus.i_rx_done = 1'b0;
    tick();
    check_zero("rst_op");
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.o_tx_start !== 1'b0) quiet = 1'b0;
    end
    chk("rst_op_quiet", quiet, 1);
    run_cmd(8'h30, 8'h0C, 8'h20, 0, 1'b0, 1'b1);

    // reset in S_WAIT_TX
    run_cmd(8'h40, 8'h02, 8'h22, 0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    check_zero("rst_tx");
    rst_n = 1'b1;
    bus.i_tx_busy = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.o_tx_start !== 1'b0) quiet = 1'b0;
    end
    chk("rst_tx_quiet", quiet, 1);
    run_cmd(8'h07, 8'h08, 8'h20, 0, 1'b0, 1'b1);

`ifdef UART_IF_TIMEOUT_EN
    // lone byte then silence -> timeout pulse 16 cycles later
    send_byte(8'h07);
    k = 0;
    while (k < 40 && bus.o_timeout !== 1'b1) begin
      tick();
      k++;
    end
    chk("timeout_latency", k, 16);
    chk("timeout_keep_a", bus.o_data_a, 8'h07);
    tick();
    chk("timeout_pulse", bus.o_timeout, 0);
    run_cmd(8'h04, 8'h05, 8'h20, 0, 1'b0, 1'b1);
`endif

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
